// File: rtl/qed_pkg.sv
// Shared constants and types for the QED instruction-memory read path.
package qed_pkg;

    localparam logic [31:0] QED_NOP    = 32'h0000_0013;
    localparam int          WORD_BYTES = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_FULL = 2'd2
    } qed_state_e;

endpackage

// File: rtl/qed_sync_fifo.sv
// Single-clock FIFO with synchronous clear; DEPTH must be a power of two.
module qed_sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_idx_q;
    logic [AW-1:0]    rd_idx_q;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & (~full | pop_i) & ~clear_i;
    assign pop_ok  = pop_i & ~empty_o & ~clear_i;
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_idx_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_idx_q <= wr_idx_q + AW'(1);
            if (pop_ok)  rd_idx_q <= rd_idx_q + AW'(1);
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Data array needs no reset; the count gates every read of it.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_idx_q] <= wdata_i;
    end

endmodule

// File: rtl/qed_mem_reader.sv
// Read side of the QED instruction memory: follows the writer pointer and
// streams committed words through a small output FIFO to the fetch stage.
//
// state  | meaning
// S_IDLE | rd_ptr caught up with the writer, nothing to fetch
// S_READ | committed words pending and buffer credit available, issuing
// S_FULL | buffer credit exhausted, waiting for the consumer
module qed_mem_reader
    import qed_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] wr_ptr_i,
    input  logic              flush_i,
    output logic              mem_ren_o,
    output logic [ADDR_W-1:0] mem_raddr_o,
    input  logic [31:0]       mem_rdata_i,
    output logic [31:0]       instr_o,
    output logic              instr_vld_o,
    input  logic              instr_rdy_i
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int CRED_W = CNT_W + 1;

    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_nxt;
    logic              inflight_q;
    logic              stale_q;
    qed_state_e        state_q;

    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_empty;
    logic [31:0]       fifo_head;

    logic              pop;
    logic              push;
    logic              issue;
    logic              inflight_live;
    logic              ptr_ne;
    logic [CRED_W-1:0] credit;
    logic [CRED_W-1:0] credit_nxt;

    assign instr_vld_o   = ~fifo_empty;
    assign instr_o       = fifo_empty ? QED_NOP : fifo_head;
    assign pop           = instr_vld_o & instr_rdy_i;
    assign inflight_live = inflight_q & ~stale_q;
    assign push          = inflight_live & ~flush_i;
    assign ptr_ne        = (rd_ptr_q != wr_ptr_i);

    assign credit = CRED_W'(fifo_cnt) + CRED_W'(inflight_live) - CRED_W'(pop);

    // Reset gates issue directly so mem_ren_o drops the moment rst_ni falls.
    assign issue = rst_ni & ptr_ne & (credit < CRED_W'(FIFO_DEPTH)) & ~flush_i;

    assign mem_ren_o   = issue;
    assign mem_raddr_o = rd_ptr_q;

    assign rd_ptr_nxt = issue ? rd_ptr_q + ADDR_W'(WORD_BYTES) : rd_ptr_q;
    assign credit_nxt = CRED_W'(fifo_cnt) + CRED_W'(push) - CRED_W'(pop)
                      + CRED_W'(issue);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q   <= BASE_ADDR;
            inflight_q <= 1'b0;
            stale_q    <= 1'b0;
            state_q    <= S_IDLE;
        end else begin
            inflight_q <= issue;
            stale_q    <= flush_i;
            if (flush_i) begin
                rd_ptr_q <= BASE_ADDR;
                state_q  <= S_IDLE;
            end else begin
                rd_ptr_q <= rd_ptr_nxt;
                case (state_q)
                    S_IDLE: begin
                        if (ptr_ne) state_q <= S_READ;
                    end
                    S_READ: begin
                        if (rd_ptr_nxt == wr_ptr_i)
                            state_q <= S_IDLE;
                        else if (credit_nxt >= CRED_W'(FIFO_DEPTH))
                            state_q <= S_FULL;
                    end
                    S_FULL: begin
                        if (credit < CRED_W'(FIFO_DEPTH))
                            state_q <= ptr_ne ? S_READ : S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    qed_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (flush_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (mem_rdata_i),
        .rdata_o (fifo_head),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty)
    );

endmodule
